// File: rtl/mips_pkg.sv
// mips_pkg
// Shared definitions for the MIPS single-cycle datapath: the HALT and NOP
// instruction words, opcode/funct encodings used by control and ALUcontrol,
// the fetch-stage state enum, and small helpers for the fetch redirect math.
// No ports (package).
package mips_pkg;

  // Special instruction words seen by the fetch stage
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP       = 32'h0000_0000;

  // Primary opcode field (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct field (instr[5:0])
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  // Fetch stage control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  // Branch displacement: sign-extended word offset turned into a byte offset
  function automatic logic [31:0] branchOffset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

  // Jump target: keeps the 256 MB region of the delay-slot PC
  function automatic logic [31:0] jumpTarget(input logic [31:0] pcPlus4,
                                             input logic [25:0] target);
    return {pcPlus4[31:28], target, 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if
// Bundles the fetch stage's control, redirect, instruction-memory load and
// instruction output signals.
//   master : decode/ALU side and memory loader (drives control/redirect/load,
//            receives instr, pc_out, pc_plus4, instr_valid, halted)
//   slave  : the fetch stage itself
// Parameter AW is the instruction memory word-address width.
interface instr_fetch_if #(parameter int AW = 10);

  logic          start;
  logic          stall;
  logic          br_taken;
  logic [15:0]   br_imm;
  logic          jump;
  logic [25:0]   j_target;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic [31:0]   instr;
  logic [31:0]   pc_out;
  logic [31:0]   pc_plus4;
  logic          instr_valid;
  logic          halted;

  modport master (
    output start, stall, br_taken, br_imm, jump, j_target,
    output imem_we, imem_waddr, imem_wdata,
    input  instr, pc_out, pc_plus4, instr_valid, halted
  );

  modport slave (
    input  start, stall, br_taken, br_imm, jump, j_target,
    input  imem_we, imem_waddr, imem_wdata,
    output instr, pc_out, pc_plus4, instr_valid, halted
  );

endinterface

// File: rtl/instr_fetch_imem.sv
// instr_fetch_imem
// Instruction memory (imem) for the fetch stage: WORDS x 32 RAM with one
// write port and one synchronous read port with read enable.
//   i_clk    : clock
//   i_we     : write strobe
//   i_waddr  : write word address
//   i_wdata  : write data
//   i_re     : read enable; o_rdata holds its value while low
//   i_raddr  : read word address
//   o_rdata  : registered read data
module instr_fetch_imem #(
  parameter int WORDS = 1024,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [WORDS];

  // Write and read share one edge; the read samples the array before the
  // write lands, so a same-address read in the write cycle returns old data.
  // The read register only advances when enabled, which lets the fetch stage
  // hold its instruction during stall and halt without a second copy.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      o_rdata <= r_mem[i_raddr];
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch
// MIPS fetch stage: program counter, instruction memory, IDLE/RUN/HALT
// control, jump/branch redirect with a one-cycle squash, stall hold.
//   clk, rst_n : clock, synchronous active-low reset
//   bus.start        : leave IDLE and begin fetching
//   bus.stall        : hold PC, IR, pc_out and instr_valid
//   bus.br_taken/br_imm : taken branch for the instruction in IR
//   bus.jump/j_target   : jump for the instruction in IR (beats branch)
//   bus.imem_we/imem_waddr/imem_wdata : instruction memory load port
//   bus.instr, pc_out, pc_plus4 : current instruction and its PC (+4)
//   bus.instr_valid  : instr is real and not squashed
//   bus.halted       : HALT state reached
module instr_fetch
  import mips_pkg::*;
#(
  parameter int          IMEM_WORDS = 1024,
  parameter int          AW         = $clog2(IMEM_WORDS),
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input logic          clk,
  input logic          rst_n,
  instr_fetch_if.slave bus
);

  fetch_state_t r_state;
  fetch_state_t w_nextState;

  logic [31:0] r_pc;
  logic [31:0] r_pcOut;
  logic        r_instrValid;
  logic        r_irMask;

  logic [31:0] w_rdata;
  logic [31:0] w_instr;
  logic [31:0] w_pcPlus4;
  logic [31:0] w_nextPc;
  logic        w_fetch;
  logic        w_enterHalt;
  logic        w_haltSeen;
  logic        w_redirect;

  // The RAM read register acts as IR. A mask flag forces it to read as NOP
  // after reset and for the squashed wrong-path word, so IR never needs its
  // own copy of the data.
  assign w_instr    = r_irMask ? NOP : w_rdata;
  assign w_pcPlus4  = r_pcOut + 32'd4;
  assign w_haltSeen = r_instrValid && (w_instr == HALT_WORD);

  // A redirect belongs to the instruction currently in IR, so it only counts
  // when that instruction is real and the stage is actually advancing.
  assign w_redirect = w_fetch && r_instrValid && (bus.jump || bus.br_taken);

  // Next PC: jump beats branch; both are relative to the IR's PC + 4.
  always_comb begin
    w_nextPc = r_pc + 32'd4;
    if (w_redirect) begin
      if (bus.jump) begin
        w_nextPc = jumpTarget(w_pcPlus4, bus.j_target);
      end else begin
        w_nextPc = w_pcPlus4 + branchOffset(bus.br_imm);
      end
    end
  end

  // State register for the fetch controller.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and fetch enable. A valid HALT_WORD in IR stops fetching
  // immediately, so the halt word stays in IR with its PC once HALT is entered;
  // it wins over stall because nothing after it may be fetched.
  always_comb begin
    w_nextState = r_state;
    w_fetch     = 1'b0;
    w_enterHalt = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_nextState = RUN;
        end
      end
      RUN: begin
        if (w_haltSeen) begin
          w_nextState = HALT;
          w_enterHalt = 1'b1;
        end else if (!bus.stall) begin
          w_fetch = 1'b1;
        end
      end
      HALT: begin
        w_nextState = HALT;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // PC, pc_out, valid and IR-mask update. On a redirect the word read this
  // edge is wrong-path: it is masked to NOP and marked invalid, giving one
  // bubble before the target word arrives.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc         <= RESET_PC;
      r_pcOut      <= RESET_PC;
      r_instrValid <= 1'b0;
      r_irMask     <= 1'b1;
    end else if (w_fetch) begin
      r_pcOut      <= r_pc;
      r_pc         <= w_nextPc;
      r_instrValid <= !w_redirect;
      r_irMask     <= w_redirect;
    end else if (w_enterHalt) begin
      r_instrValid <= 1'b0;
    end
  end

  instr_fetch_imem #(
    .WORDS (IMEM_WORDS),
    .AW    (AW)
  ) u_imem (
    .i_clk   (clk),
    .i_we    (bus.imem_we),
    .i_waddr (bus.imem_waddr),
    .i_wdata (bus.imem_wdata),
    .i_re    (w_fetch),
    .i_raddr (r_pc[AW+1:2]),
    .o_rdata (w_rdata)
  );

  assign bus.instr       = w_instr;
  assign bus.pc_out      = r_pcOut;
  assign bus.pc_plus4    = w_pcPlus4;
  assign bus.instr_valid = r_instrValid;
  assign bus.halted      = (r_state == HALT);

endmodule
